// File: rtl/skinny_tk_sched_ctrl.sv
// Tweakey-schedule sequencer: loads the masked key once per block, then pulses one
// key update per LAT-cycle masked round while stepping the round index and round constant.
module skinny_tk_sched_ctrl #(
  parameter int NR  = 56,
  parameter int LAT = 6,
  localparam int RW = $clog2(NR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          ready,
  output logic          busy,
  output logic          ks_sel,
  output logic          ks_en,
  output logic          round_start,
  output logic [RW-1:0] rnd_idx,
  output logic [5:0]    rc,
  output logic          done
);

  localparam int PW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(LAT - 1);
  localparam logic [RW-1:0] IDX_LAST = RW'(NR - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [RW-1:0] rnd_idx_q, rnd_idx_d;
  logic [5:0]    rc_q, rc_d;
  logic          ks_en_q, ks_en_d;
  logic          ks_sel_q, ks_sel_d;
  logic          round_start_q, round_start_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rnd_idx_d = rnd_idx_q;
    rc_d      = rc_q;
    ks_en_d   = 1'b0;

    // ks_en is registered: it is decided one cycle ahead, so the pulse for the
    // update ending a round lands on phase 0 of the following round.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ks_en_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_ROUND;
          rc_d      = 6'h01;
          rnd_idx_d = '0;
          phase_d   = '0;
        end
      end
      S_ROUND: begin
        if (abort) begin
          state_d = S_IDLE;
          phase_d = '0;
        end else if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (rnd_idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            ks_en_d   = 1'b1;
            rnd_idx_d = rnd_idx_q + RW'(1);
            rc_d      = {rc_q[4:0], rc_q[5] ^ rc_q[4] ^ 1'b1};
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d       = (state_d == S_IDLE);
    busy_d        = (state_d == S_LOAD) || (state_d == S_ROUND);
    ks_sel_d      = (state_d == S_ROUND);
    round_start_d = (state_d == S_ROUND) && (phase_d == '0);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      rnd_idx_q     <= '0;
      rc_q          <= 6'h00;
      ks_en_q       <= 1'b0;
      ks_sel_q      <= 1'b0;
      round_start_q <= 1'b0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      rnd_idx_q     <= rnd_idx_d;
      rc_q          <= rc_d;
      ks_en_q       <= ks_en_d;
      ks_sel_q      <= ks_sel_d;
      round_start_q <= round_start_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign ready       = ready_q;
  assign busy        = busy_q;
  assign ks_sel      = ks_sel_q;
  assign ks_en       = ks_en_q;
  assign round_start = round_start_q;
  assign rnd_idx     = rnd_idx_q;
  assign rc          = rc_q;
  assign done        = done_q;

endmodule

// File: tb/tb_skinny_tk_sched_ctrl.sv
// Directed bench: instance A (NR=4, LAT=3) for nominal/abort/reset/back-to-back,
// instance B (NR=56, LAT=1) for the single-cycle round case.
module tb_skinny_tk_sched_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic a_start, a_abort, b_start, b_abort;

  logic       a_ready, a_busy, a_ks_sel, a_ks_en, a_round_start, a_done;
  logic [1:0] a_rnd_idx;
  logic [5:0] a_rc;
  logic       b_ready, b_busy, b_ks_sel, b_ks_en, b_round_start, b_done;
  logic [5:0] b_rnd_idx;
  logic [5:0] b_rc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] rc_tab [4] = '{6'h01, 6'h03, 6'h07, 6'h0F};

  always #5 clk = ~clk;

  skinny_tk_sched_ctrl #(.NR(4), .LAT(3)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .ready(a_ready), .busy(a_busy), .ks_sel(a_ks_sel), .ks_en(a_ks_en),
    .round_start(a_round_start), .rnd_idx(a_rnd_idx), .rc(a_rc), .done(a_done)
  );

  skinny_tk_sched_ctrl #(.NR(56), .LAT(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .ready(b_ready), .busy(b_busy), .ks_sel(b_ks_sel), .ks_en(b_ks_en),
    .round_start(b_round_start), .rnd_idx(b_rnd_idx), .rc(b_rc), .done(b_done)
  );

  task automatic test_reset();
    rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0; b_abort = 1'b0;
    #3;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
    n_checks++; if (a_ks_en !== 1'b0) begin n_fail++; $display("FAIL reset_ks_en got=%b exp=0", a_ks_en); end
    n_checks++; if (a_rc !== 6'h00) begin n_fail++; $display("FAIL reset_rc got=%h exp=00", a_rc); end
    n_checks++; if (a_rnd_idx !== 2'd0) begin n_fail++; $display("FAIL reset_rnd_idx got=%0d exp=0", a_rnd_idx); end
    n_checks++; if ({a_busy, a_done, a_ks_sel, a_round_start} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {a_busy, a_done, a_ks_sel, a_round_start});
    end
    n_checks++; if (b_ready !== 1'b1 || b_rc !== 6'h00) begin
      n_fail++; $display("FAIL reset_b got ready=%b rc=%h exp ready=1 rc=00", b_ready, b_rc);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: done");
  endtask

  // Runs one full block on A starting in the current cycle (t0); returns in IDLE at t16.
  task automatic run_block_a(input string tag);
    logic exp_en, exp_rs, exp_done;
    int idx;
    a_start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 1) a_start = 1'b0;
      exp_en   = (k == 1) || (k == 5) || (k == 8) || (k == 11);
      exp_rs   = (k == 2) || (k == 5) || (k == 8) || (k == 11);
      exp_done = (k == 14);
      n_checks++; if (a_ks_en !== exp_en) begin n_fail++; $display("FAIL %s ks_en t%0d got=%b exp=%b", tag, k, a_ks_en, exp_en); end
      n_checks++; if (a_round_start !== exp_rs) begin n_fail++; $display("FAIL %s round_start t%0d got=%b exp=%b", tag, k, a_round_start, exp_rs); end
      n_checks++; if (a_done !== exp_done) begin n_fail++; $display("FAIL %s done t%0d got=%b exp=%b", tag, k, a_done, exp_done); end
      n_checks++; if (a_busy !== (k <= 13)) begin n_fail++; $display("FAIL %s busy t%0d got=%b exp=%b", tag, k, a_busy, k <= 13); end
      n_checks++; if (a_ready !== (k >= 15)) begin n_fail++; $display("FAIL %s ready t%0d got=%b exp=%b", tag, k, a_ready, k >= 15); end
      if (exp_en) begin
        n_checks++; if (a_ks_sel !== (k != 1)) begin n_fail++; $display("FAIL %s ks_sel t%0d got=%b exp=%b", tag, k, a_ks_sel, k != 1); end
      end
      if (k >= 2 && k <= 13) begin
        idx = (k - 2) / 3;
        n_checks++; if (a_rc !== rc_tab[idx]) begin n_fail++; $display("FAIL %s rc t%0d got=%h exp=%h", tag, k, a_rc, rc_tab[idx]); end
        n_checks++; if (a_rnd_idx !== 2'(idx)) begin n_fail++; $display("FAIL %s rnd_idx t%0d got=%0d exp=%0d", tag, k, a_rnd_idx, idx); end
      end
    end
    $display("%s: block complete", tag);
  endtask

  task automatic test_nominal();
    run_block_a("nominal");
  endtask

  task automatic test_lat1();
    int pulses = 0;
    logic exp_en;
    b_start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 1) b_start = 1'b0;
      if (b_ks_en === 1'b1) pulses++;
      exp_en = (k == 1) || (k >= 3 && k <= 57);
      n_checks++; if (b_ks_en !== exp_en) begin n_fail++; $display("FAIL lat1 ks_en t%0d got=%b exp=%b", k, b_ks_en, exp_en); end
      n_checks++; if (b_done !== (k == 58)) begin n_fail++; $display("FAIL lat1 done t%0d got=%b exp=%b", k, b_done, k == 58); end
      if (k == 7) begin
        n_checks++; if (b_rc !== 6'h3E || b_rnd_idx !== 6'd5) begin
          n_fail++; $display("FAIL lat1 rc_round5 got rc=%h idx=%0d exp rc=3e idx=5", b_rc, b_rnd_idx);
        end
      end
    end
    n_checks++; if (pulses != 56) begin n_fail++; $display("FAIL lat1 pulse_count got=%0d exp=56", pulses); end
    $display("lat1: block complete, %0d key pulses", pulses);
  endtask

  task automatic test_abort();
    a_start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) a_start = 1'b0;
    end
    // t9 is round 2, phase 1
    n_checks++; if (a_rnd_idx !== 2'd2) begin n_fail++; $display("FAIL abort pre_idx got=%0d exp=2", a_rnd_idx); end
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    n_checks++; if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL abort idle got ready=%b busy=%b exp ready=1 busy=0", a_ready, a_busy);
    end
    n_checks++; if (a_rc !== 6'h07 || a_rnd_idx !== 2'd2) begin
      n_fail++; $display("FAIL abort hold got rc=%h idx=%0d exp rc=07 idx=2", a_rc, a_rnd_idx);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (a_ks_en !== 1'b0 || a_done !== 1'b0) begin
        n_fail++; $display("FAIL abort quiet c%0d got ks_en=%b done=%b exp 0 0", k, a_ks_en, a_done);
      end
      @(posedge clk); #1;
    end
    $display("abort: cancelled in round 2");
    run_block_a("after_abort");
  endtask

  task automatic test_back_to_back();
    int j;
    logic exp_en;
    a_start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      j = (k - 1) % 15 + 1;
      exp_en = (j == 1) || (j == 5) || (j == 8) || (j == 11);
      n_checks++; if (a_ks_en !== exp_en) begin n_fail++; $display("FAIL b2b ks_en t%0d got=%b exp=%b", k, a_ks_en, exp_en); end
      n_checks++; if (a_done !== (j == 14)) begin n_fail++; $display("FAIL b2b done t%0d got=%b exp=%b", k, a_done, j == 14); end
      if (j == 1) begin
        n_checks++; if (a_ks_sel !== 1'b0) begin n_fail++; $display("FAIL b2b load_sel t%0d got=%b exp=0", k, a_ks_sel); end
      end
      if (j == 2) begin
        n_checks++; if (a_rc !== 6'h01) begin n_fail++; $display("FAIL b2b rc_init t%0d got=%h exp=01", k, a_rc); end
      end
      if (j == 14) $display("b2b: block done at t%0d", k);
    end
    a_start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    a_start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) a_start = 1'b0;
    end
    n_checks++; if (a_rnd_idx !== 2'd3) begin n_fail++; $display("FAIL rst_mid pre_idx got=%0d exp=3", a_rnd_idx); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_ks_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid flags got ready=%b busy=%b ks_en=%b exp 1 0 0", a_ready, a_busy, a_ks_en);
    end
    n_checks++; if (a_rc !== 6'h00 || a_rnd_idx !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid regs got rc=%h idx=%0d exp rc=00 idx=0", a_rc, a_rnd_idx);
    end
    @(posedge clk); #3 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_checks++; if (a_done !== 1'b0 || a_ready !== 1'b1) begin
        n_fail++; $display("FAIL rst_mid after c%0d got done=%b ready=%b exp 0 1", k, a_done, a_ready);
      end
    end
    $display("rst_mid: reset during round 3");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lat1();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
